// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: line-format enums, FSM state
// and the data-width clamp used when a frame's format is latched.
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone = 2'd0,
    ParOdd  = 2'd1,
    ParEven = 2'd2
  } parity_t;

  typedef enum logic {
    StopOne = 1'b0,
    StopTwo = 1'b1
  } stop_bits_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StBreak
  } rx_state_t;

  localparam int unsigned MinDataBits = 5;

  function automatic logic [3:0] clamp_bits(input logic [3:0] n, input int unsigned max_bits);
    if (n < 4'(MinDataBits)) return 4'(MinDataBits);
    if (32'(n) > max_bits) return 4'(max_bits);
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-word buffer: power-of-two circular FIFO with occupancy count.
// A pop and a push in the same cycle on a full buffer both succeed.
module uart_rx_fifo #(
  parameter int unsigned Width = 11,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt_q;
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote bit decisions and a word FIFO.
// Define UART_RX_BREAK_DETECT_EN to turn all-zero frames into an rx_break pulse.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DIV_W         = 16,
  localparam int unsigned CntW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [3:0]               num_data_bits,
  input  parity_t                  parity,
  input  stop_bits_t               stop_bits,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     rx_overrun,
  input  logic                     ovr_clr,
  output logic                     rx_break,
  output logic                     rx_busy,
  output logic [CntW-1:0]          fifo_count
);

  localparam int unsigned PhW   = $clog2(OVERSAMPLE);
  localparam int unsigned WordW = MAX_DATA_BITS + 2;
  localparam logic [PhW-1:0] PhS0   = PhW'(OVERSAMPLE / 2 - 1);
  localparam logic [PhW-1:0] PhS1   = PhW'(OVERSAMPLE / 2);
  localparam logic [PhW-1:0] PhS2   = PhW'(OVERSAMPLE / 2 + 1);
  localparam logic [PhW-1:0] PhLast = PhW'(OVERSAMPLE - 1);

  logic rx_meta_q, rx_s_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  rx_state_t                state_q;
  logic [PhW-1:0]           phase_q;
  logic [3:0]               bit_idx_q, nbits_q;
  parity_t                  par_q;
  stop_bits_t               stop_q;
  logic [DIV_W-1:0]         div_q, div_cnt_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic [1:0]               smp_q;
  logic                     all0_q, perr_q, ferr_q, hi_q, push_q, brk_q;
  logic [WordW-1:0]         word_q;

  logic tick, rx_fall, maj, par_x, frame_end, fe, is_break;

  assign tick    = (div_cnt_q == '0);
  assign rx_fall = (state_q == StIdle) & rx_prev_q & ~rx_s_q;
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
  assign par_x   = (^data_q) ^ maj;
  assign frame_end = (phase_q == PhS2) &
                     (((state_q == StStop1) & (stop_q == StopOne)) | (state_q == StStop2));
  // Stop-1 result is only meaningful when a second stop bit follows it.
  assign fe      = ((state_q == StStop2) & ferr_q) | ~maj;
`ifdef UART_RX_BREAK_DETECT_EN
  assign is_break = all0_q & ~maj;
`else
  assign is_break = 1'b0;
`endif

  // Divisor restarts on the start edge so sample phases are aligned to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
    end else if (rx_fall) begin
      div_cnt_q <= baud_div;
    end else if (tick) begin
      div_cnt_q <= (state_q == StIdle) ? baud_div : div_q;
    end else begin
      div_cnt_q <= div_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      bit_idx_q <= '0;
      nbits_q   <= '0;
      par_q     <= ParNone;
      stop_q    <= StopOne;
      div_q     <= '0;
      data_q    <= '0;
      smp_q     <= '0;
      all0_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      hi_q      <= 1'b0;
      push_q    <= 1'b0;
      word_q    <= '0;
      brk_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      brk_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_fall) begin
            phase_q   <= '0;
            bit_idx_q <= '0;
            nbits_q   <= clamp_bits(num_data_bits, MAX_DATA_BITS);
            par_q     <= parity;
            stop_q    <= stop_bits;
            div_q     <= baud_div;
            data_q    <= '0;
            smp_q     <= '0;
            all0_q    <= 1'b1;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            state_q   <= StStart;
          end
        end
        // Leave only after the line has stayed high across a whole tick interval.
        StBreak: begin
          if (!rx_s_q) begin
            hi_q <= 1'b0;
          end else if (tick) begin
            if (hi_q) state_q <= StIdle;
            hi_q <= 1'b1;
          end
        end
        default: begin
          if (tick) begin
            phase_q <= (phase_q == PhLast) ? '0 : phase_q + 1'b1;
            if (phase_q == PhS0) smp_q[0] <= rx_s_q;
            if (phase_q == PhS1) smp_q[1] <= rx_s_q;
            if (phase_q == PhS2) begin
              if (maj) all0_q <= 1'b0;
              case (state_q)
                StStart:  if (maj) state_q <= StIdle;
                StData:   data_q[bit_idx_q] <= maj;
                StParity: perr_q <= (par_q == ParOdd) ? ~par_x : par_x;
                StStop1:  ferr_q <= ~maj;
                default:  ;
              endcase
            end
            if (phase_q == PhLast) begin
              case (state_q)
                StStart: state_q <= StData;
                StData: begin
                  if (bit_idx_q == nbits_q - 4'd1) begin
                    state_q <= (par_q == ParNone) ? StStop1 : StParity;
                  end else begin
                    bit_idx_q <= bit_idx_q + 4'd1;
                  end
                end
                StParity: state_q <= StStop1;
                StStop1:  state_q <= StStop2;
                default:  ;
              endcase
            end
            if (frame_end) begin
              if (is_break) begin
                brk_q   <= 1'b1;
                hi_q    <= 1'b0;
                state_q <= StBreak;
              end else begin
                push_q  <= 1'b1;
                word_q  <= {perr_q, fe, data_q};
                state_q <= StIdle;
              end
            end
          end
        end
      endcase
    end
  end

  logic             fifo_full, fifo_empty, pop, ovr_q;
  logic [WordW-1:0] head;

  assign pop = rx_valid & rx_ready;

  uart_rx_fifo #(
    .Width(WordW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_q),
    .wdata(word_q),
    .pop  (pop),
    .rdata(head),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= 1'b0;
    end else if (push_q & fifo_full & ~pop) begin
      ovr_q <= 1'b1;
    end else if (ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end

  assign rx_valid      = ~fifo_empty;
  assign rx_data       = head[MAX_DATA_BITS-1:0];
  assign rx_frame_err  = head[MAX_DATA_BITS];
  assign rx_parity_err = head[MAX_DATA_BITS+1];
  assign rx_overrun    = ovr_q;
  assign rx_break      = brk_q;
  assign rx_busy       = (state_q != StIdle);

endmodule
